chan_framer: RTL and testbench
==============================

Name: chan_framer

Overview:
- Sits directly downstream of the channel splitter in the FMCW receive path.
- Takes per-channel ADC samples (A, B) plus a chirp-start strobe and builds one frame per chirp: header word, SAMPLES sample slots, footer word.
- Buffers frame words in a small synchronous FIFO and presents them on a valid/ready stream to the host-transfer logic.

Parameters:
- OW, 14, sample width out of the channel splitter (two's complement).
- DW, 16, output word width; samples are sign-extended from OW to DW.
- SAMPLES, 2048, sample slots (accepted valid_i events) per frame.
- FIFO_AW, 5, FIFO address width; depth = 2^FIFO_AW words.
- HDR, 16'hA5A5, header word.
- FTR, 16'h5A5A, footer word.

Ports:
- clk_i, input, 1, system clock; all logic on its rising edge.
- rst_n_i, input, 1, reset; asynchronous assert, active-low.
- chirp_start_i, input, 1, single-cycle strobe marking chirp start.
- mode_i, input, 2, channel select: 0 = A only, 1 = B only, 2 = A then B, 3 = reserved (treated as 0).
- valid_i, input, 1, chan_a_i and chan_b_i are valid this cycle.
- chan_a_i, input, OW, channel A sample.
- chan_b_i, input, OW, channel B sample.
- data_o, output, DW, frame word at the FIFO head.
- valid_o, output, 1, data_o is valid.
- ready_i, input, 1, downstream accepts data_o.
- busy_o, output, 1, a frame is in progress.
- overflow_o, output, 1, sticky: a frame word was dropped.

Behaviour:
- Reset (rst_n_i low, asynchronous): state IDLE, FIFO empty, sample counter 0, pending-B register empty. Outputs: valid_o 0, data_o 0, busy_o 0, overflow_o 0.
- FSM states:
  - IDLE: chirp_start_i high -> latch mode_i, go HDR.
  - HDR: write HDR for one cycle, go DATA.
  - DATA: each valid_i is one sample slot and increments the counter. When the SAMPLESth slot has been written (including its pending B in mode 2), go FTR.
  - FTR: write FTR for one cycle, clear the counter, go IDLE.
- busy_o = (state != IDLE).
- chirp_start_i outside IDLE is ignored: no restart, no error.
- The latched mode applies for the whole frame; changes to mode_i mid-frame take effect only at the next frame.
- valid_i is ignored outside DATA, including during the HDR cycle.
- DATA writes per valid_i:
  - Mode 0: write sext(chan_a_i).
  - Mode 1: write sext(chan_b_i).
  - Mode 2: write sext(chan_a_i) this cycle, capture chan_b_i into the pending register, write it on the next cycle.
- Mode 2 gap rule: upstream guarantees at least one idle cycle between valid_i pulses. If valid_i arrives while B is still pending, the new slot is dropped: counter not incremented, overflow_o set.
- FIFO:
  - First-word-fall-through. valid_o = not empty; data_o = head word. Both are registered.
  - A written word appears on valid_o/data_o no earlier than the cycle after the write.
  - Pop on valid_o && ready_i.
  - While valid_o && !ready_i, data_o holds stable.
  - Simultaneous push and pop on a full FIFO is allowed: the pop frees the slot and the push succeeds. Push and pop on an empty FIFO: the word appears the next cycle.
  - data_o holds the last popped value when the FIFO is empty.
- Overflow:
  - A write to a full FIFO (without a same-cycle pop) drops that word and sets overflow_o.
  - The counter and FSM still advance, so the frame length in slots is unchanged but the word count is short.
  - Header and footer are dropped the same way.
  - overflow_o clears only on reset.
- Width: sext = replicate bit OW-1 into bits DW-1:OW. Requires DW >= OW.
- Counter width is clog2(SAMPLES+1); no wrap within a frame.
- Reset mid-frame aborts the frame immediately; the FIFO contents are lost.

Test Plan:
- Reset, SAMPLES=4, mode 0, A=1,2,3,4 with valid_i every cycle, ready_i=1 -> data_o sequence A5A5,0001,0002,0003,0004,5A5A; busy_o high from the cycle after the strobe until the footer is written; overflow_o 0.
- Mode 2, SAMPLES=2, valid_i every 2nd cycle, (A,B)=(0x1FFF,0x2000),(5,-5) -> A5A5,1FFF,E000,0005,FFFB,5A5A (0x2000 sign-extends to E000).
- ready_i=0 throughout, FIFO_AW=2, SAMPLES=8, mode 0 -> exactly 4 words queued (A5A5 + first 3 samples); overflow_o rises on the 5th write and stays high; FSM returns to IDLE on schedule.
- Backpressure hold: ready_i toggling 1/0 every cycle -> data_o never changes while valid_o && !ready_i; every word delivered once, in order.
- chirp_start_i pulsed again mid-DATA, and mode_i changed mid-frame -> frame length and mode unchanged; no extra header.
- rst_n_i pulsed low mid-DATA (asynchronous, between clock edges) -> valid_o, busy_o and overflow_o go to 0 without waiting for a clock edge; the next chirp_start_i produces a clean full frame.

Source files
------------

// File: rtl/chan_framer.sv
// Frames per-chirp channel samples as header, SAMPLES sample slots, footer,
// and streams the words out through a small first-word-fall-through FIFO.
module chan_framer #(
    parameter int OW      = 14,
    parameter int DW      = 16,
    parameter int SAMPLES = 2048,
    parameter int FIFO_AW = 5,
    parameter logic [DW-1:0] HDR = 16'hA5A5,
    parameter logic [DW-1:0] FTR = 16'h5A5A
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          chirp_start_i,
    input  logic [1:0]    mode_i,
    input  logic          valid_i,
    input  logic [OW-1:0] chan_a_i,
    input  logic [OW-1:0] chan_b_i,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic          busy_o,
    output logic          overflow_o
);

    // Stream handshake: a word transfers on every rising edge where
    // valid_o && ready_i; data_o is held stable while valid_o && !ready_i.

    localparam int CW    = $clog2(SAMPLES + 1);
    localparam int CNTW  = FIFO_AW + 1;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLES - 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(SAMPLES);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_FTR} state_t;

    function automatic logic [DW-1:0] sext(input logic [OW-1:0] x);
        logic signed [OW-1:0] s;
        s = x;
        return DW'(s);
    endfunction

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         mode_q, mode_d;
    logic               pend_q, pend_d;
    logic [OW-1:0]      pend_data_q, pend_data_d;
    logic               overflow_q, overflow_d;

    logic [DW-1:0]      mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]    count_q, count_d, remain;
    logic               valid_q, valid_d;
    logic [DW-1:0]      data_q, data_d;

    logic               wr_req, slot_drop, push, pop, full, fifo_drop;
    logic [DW-1:0]      wr_data;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        wr_req      = 1'b0;
        wr_data     = '0;
        slot_drop   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (chirp_start_i) begin
                    mode_d  = (mode_i == 2'd3) ? 2'd0 : mode_i;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                wr_req  = 1'b1;
                wr_data = HDR;
                state_d = S_DATA;
            end
            S_DATA: begin
                if (pend_q) begin
                    // The pending B owns the write port; a colliding slot is lost.
                    wr_req    = 1'b1;
                    wr_data   = sext(pend_data_q);
                    pend_d    = 1'b0;
                    slot_drop = valid_i;
                    if (cnt_q == CNT_DONE) begin
                        state_d = S_FTR;
                    end
                end else if (valid_i) begin
                    wr_req = 1'b1;
                    cnt_d  = cnt_q + CW'(1);
                    case (mode_q)
                        2'd1:    wr_data = sext(chan_b_i);
                        2'd2: begin
                            wr_data     = sext(chan_a_i);
                            pend_d      = 1'b1;
                            pend_data_d = chan_b_i;
                        end
                        default: wr_data = sext(chan_a_i);
                    endcase
                    if (mode_q != 2'd2 && cnt_q == CNT_LAST) begin
                        state_d = S_FTR;
                    end
                end
            end
            S_FTR: begin
                wr_req  = 1'b1;
                wr_data = FTR;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pop       = valid_q && ready_i;
        full      = count_q[FIFO_AW];
        push      = wr_req && (!full || pop);
        fifo_drop = wr_req && full && !pop;
        wr_ptr_d  = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        count_d   = count_q;
        if (push && !pop) begin
            count_d = count_q + CNTW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNTW'(1);
        end
        remain = count_q - CNTW'(pop);
        // Head register: next stored word, else the word arriving into an empty FIFO.
        data_d = data_q;
        if (remain != '0) begin
            data_d = mem_q[rd_ptr_d];
        end else if (push) begin
            data_d = wr_data;
        end
        valid_d    = (count_d != '0);
        overflow_d = overflow_q || slot_drop || fifo_drop;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mode_q      <= 2'd0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign busy_o     = (state_q != S_IDLE);
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_chan_framer.sv
// Directed bench for chan_framer (SAMPLES=4, 4-word FIFO): vector table of
// frames plus hand sequences for overflow, gap violation and async reset.
module tb_chan_framer;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        chirp_start_i = 1'b0;
    logic [1:0]  mode_i = 2'd0;
    logic        valid_i = 1'b0;
    logic [13:0] chan_a_i = '0;
    logic [13:0] chan_b_i = '0;
    logic [15:0] data_o;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic        busy_o;
    logic        overflow_o;

    chan_framer #(.OW(14), .DW(16), .SAMPLES(4), .FIFO_AW(2),
                  .HDR(16'hA5A5), .FTR(16'h5A5A)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .chirp_start_i(chirp_start_i),
        .mode_i(mode_i), .valid_i(valid_i), .chan_a_i(chan_a_i),
        .chan_b_i(chan_b_i), .data_o(data_o), .valid_o(valid_o),
        .ready_i(ready_i), .busy_o(busy_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [1:0]        mode;
        logic [3:0][13:0]  a;
        logic [3:0][13:0]  b;
        logic [3:0]        gap;
        logic              rdy_tgl;
        logic [3:0]        n_exp;
        logic [9:0][15:0]  exp_w;
    } vec_t;

    vec_t        vecs [4];
    vec_t        dv;
    logic [15:0] exp_q [$];
    int          n_chk = 0;
    int          n_err = 0;
    int          rdy_mode = 0;
    bit          prev_v = 1'b0;
    bit          prev_r = 1'b0;
    logic [15:0] prev_d = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // 0: ready always high, 1: toggles each cycle, 2: held low
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (rdy_mode == 0) ready_i = 1'b1;
            else if (rdy_mode == 1) ready_i = ~ready_i;
            else ready_i = 1'b0;
        end
    end

    // Scoreboard: every popped word against the expected queue, plus hold check.
    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                check("hold_valid", valid_o, 1);
                check("hold_data", data_o, prev_d);
            end
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", data_o, 32'hFFFF_FFFF);
                end else begin
                    check("word", data_o, exp_q.pop_front());
                end
            end
            prev_v = valid_o;
            prev_r = ready_i;
            prev_d = data_o;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((exp_q.size() != 0 || valid_o) && k < 200) begin
            @(negedge clk_i);
            k++;
        end
        check("drain_timeout", (k < 200), 1);
        check("drain_left", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #3 rst_n_i = 1'b0;
        #1;
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ovf", overflow_o, 0);
        exp_q.delete();
        #10 rst_n_i = 1'b1;
    endtask

    task automatic drive_frame(input vec_t v, input bit disturb);
        int lat;
        rdy_mode = v.rdy_tgl ? 1 : 0;
        for (int i = 0; i < int'(v.n_exp); i++) exp_q.push_back(v.exp_w[i]);
        tick();
        check("busy_idle", busy_o, 0);
        chirp_start_i = 1'b1;
        mode_i = v.mode;
        tick();
        chirp_start_i = 1'b0;
        check("busy_hdr", busy_o, 1);
        // Junk sample during the header cycle must not reach the FIFO.
        valid_i = 1'b1;
        chan_a_i = 14'h0777;
        chan_b_i = 14'h0777;
        tick();
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'b1;
            chan_a_i = v.a[i];
            chan_b_i = v.b[i];
            if (disturb && i == 1) begin
                chirp_start_i = 1'b1;
                mode_i = 2'd2;
            end
            tick();
            valid_i = 1'b0;
            chirp_start_i = 1'b0;
            if (i < 3) repeat (int'(v.gap)) tick();
        end
        lat = 0;
        while (busy_o && lat < 10) begin
            tick();
            lat++;
        end
        check("ftr_lat", lat, (v.mode == 2'd2) ? 2 : 1);
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '0;
        vecs[0].mode  = 2'd0;
        vecs[0].a     = {14'd4, 14'd3, 14'd2, 14'd1};
        vecs[0].b     = {4{14'h3FFF}};
        vecs[0].n_exp = 4'd6;
        vecs[0].exp_w = {64'h0, 16'h5A5A, 16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'hA5A5};

        vecs[1] = '0;
        vecs[1].mode  = 2'd2;
        vecs[1].a     = {14'h0000, 14'h2000, 14'h0005, 14'h1FFF};
        vecs[1].b     = {14'h3FFF, 14'h1FFF, 14'h3FFB, 14'h2000};
        vecs[1].gap   = 4'd1;
        vecs[1].n_exp = 4'd10;
        vecs[1].exp_w = {16'h5A5A, 16'hFFFF, 16'h0000, 16'h1FFF, 16'hE000,
                         16'hFFFB, 16'h0005, 16'hE000, 16'h1FFF, 16'hA5A5};

        vecs[2] = '0;
        vecs[2].mode    = 2'd1;
        vecs[2].b       = {14'h1000, 14'h3000, 14'h0123, 14'h2ABC};
        vecs[2].gap     = 4'd1;
        vecs[2].rdy_tgl = 1'b1;
        vecs[2].n_exp   = 4'd6;
        vecs[2].exp_w   = {64'h0, 16'h5A5A, 16'h1000, 16'hF000, 16'h0123, 16'hEABC, 16'hA5A5};

        vecs[3] = '0;
        vecs[3].mode  = 2'd3;
        vecs[3].a     = {14'h0001, 14'h1FFF, 14'h2000, 14'h3FFF};
        vecs[3].n_exp = 4'd6;
        vecs[3].exp_w = {64'h0, 16'h5A5A, 16'h0001, 16'h1FFF, 16'hE000, 16'hFFFF, 16'hA5A5};

        #3;
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ovf", overflow_o, 0);
        #20 rst_n_i = 1'b1;

        for (int t = 0; t < 4; t++) begin
            drive_frame(vecs[t], 1'b0);
            check("ovf_clean", overflow_o, 0);
        end

        // Mid-frame chirp and mode change leave the frame untouched.
        dv = vecs[0];
        for (int i = 0; i < 4; i++) begin
            dv.a[i] = 14'(16 + i);
            dv.exp_w[1 + i] = 16'(16 + i);
        end
        drive_frame(dv, 1'b1);
        check("ovf_disturb", overflow_o, 0);

        // Mode 2 with valid every cycle: every second slot collides with pending B.
        rdy_mode = 0;
        for (int i = 0; i < 8; i += 2) begin
            exp_q.push_back(16'(i + 1));
            exp_q.push_back(16'(i + 17));
        end
        exp_q.push_front(16'hA5A5);
        exp_q.push_back(16'h5A5A);
        tick();
        chirp_start_i = 1'b1;
        mode_i = 2'd2;
        tick();
        chirp_start_i = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            valid_i = 1'b1;
            chan_a_i = 14'(i + 1);
            chan_b_i = 14'(i + 17);
            tick();
        end
        valid_i = 1'b0;
        check("gap_busy_ftr", busy_o, 1);
        tick();
        check("gap_busy_idle", busy_o, 0);
        wait_drain();
        check("gap_ovf", overflow_o, 1);

        do_reset();

        // FIFO full with ready low: header plus three samples fit, rest dropped.
        rdy_mode = 2;
        tick();
        tick();
        chirp_start_i = 1'b1;
        mode_i = 2'd0;
        tick();
        chirp_start_i = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'b1;
            chan_a_i = 14'(i + 1);
            tick();
            valid_i = 1'b0;
            check("full_ovf_step", overflow_o, (i == 3) ? 1 : 0);
        end
        check("full_busy_ftr", busy_o, 1);
        tick();
        check("full_busy_idle", busy_o, 0);
        check("full_ovf", overflow_o, 1);
        check("full_valid", valid_o, 1);
        check("full_head", data_o, 16'hA5A5);
        repeat (3) tick();
        check("full_head_hold", data_o, 16'hA5A5);
        exp_q.push_back(16'hA5A5);
        for (int i = 1; i <= 3; i++) exp_q.push_back(16'(i));
        rdy_mode = 0;
        wait_drain();
        check("empty_valid", valid_o, 0);
        check("empty_hold_last", data_o, 16'h0003);
        check("full_ovf_sticky", overflow_o, 1);

        // Asynchronous reset in the middle of DATA.
        rdy_mode = 2;
        tick();
        tick();
        chirp_start_i = 1'b1;
        tick();
        chirp_start_i = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            valid_i = 1'b1;
            chan_a_i = 14'(i + 33);
            tick();
        end
        valid_i = 1'b0;
        check("pre_rst_valid", valid_o, 1);
        check("pre_rst_busy", busy_o, 1);
        check("pre_rst_ovf", overflow_o, 1);
        #2 rst_n_i = 1'b0;
        #1;
        check("async_valid", valid_o, 0);
        check("async_busy", busy_o, 0);
        check("async_ovf", overflow_o, 0);
        check("async_data", data_o, 0);
        exp_q.delete();
        #10 rst_n_i = 1'b1;
        drive_frame(vecs[0], 1'b0);
        check("post_rst_ovf", overflow_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
